// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Purpose  : Shares one word-level SPI engine among NREQ requesters. Owns the
//            per-device chip selects, sequences CS setup / word start /
//            completion wait / CS release, supports locked multi-word bursts
//            and arbitrates round-robin between bursts.
// Options  : SPI_ARB_TIMEOUT_EN - HOLD-state idle watchdog with sticky
//            timeout_err flag (disabled when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int NREQ     = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      fast,
    input  logic [32*NREQ-1:0]   tx_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rx_data,
    output logic                 busy,
    output logic [NREQ-1:0]      ss_n,
    output logic                 timeout_err,
    output logic                 spi_start,
    output logic                 spi_fast,
    output logic [31:0]          spi_dataTx,
    input  logic [31:0]          spi_dataRx,
    input  logic                 spi_rdy
);

    localparam int c_IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CMAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_CNT_W = (c_CMAX > 1) ? $clog2(c_CMAX) : 1;

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
    localparam logic [c_IDXW-1:0]  c_LAST_IDX   = c_IDXW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_START   = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4,
        S_DONE    = 3'd5,
        S_HOLD    = 3'd6,
        S_RELEASE = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDXW-1:0]   r_owner;
    logic [c_IDXW-1:0]   r_ptr;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_ss_n;
    logic [NREQ-1:0]     r_done;
    logic                r_spi_start;
    logic                r_spi_fast;
    logic [31:0]         r_spi_dataTx;
    logic [31:0]         r_rx_data;
    logic                r_busy;

    logic [2*NREQ-1:0]   w_req_rot;
    logic [c_IDXW-1:0]   w_winner;
    logic [NREQ-1:0]     w_win_oh;
    logic                w_to_expire;

    // Requests rotated so bit 0 is the requester the RR pointer favours
    assign w_req_rot = {req, req} >> r_ptr;

    // Round-robin winner: first requester at or above r_ptr, wrapping
    always_comb begin
        w_winner = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_winner = c_IDXW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout_err;

    assign w_to_expire = (r_state == S_HOLD) && (r_to_cnt == c_TO_LAST);

    // HOLD idle watchdog; restarts from zero on every entry to HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != S_HOLD) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_TO_LAST) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_expire && !req[r_owner] && lock[r_owner]) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_to_expire = 1'b0;
    // No watchdog in this build: flag is constant low (comparison is false
    // for every legal TIMEOUT setting)
    assign timeout_err = (TIMEOUT < 0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the transfer sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (spi_rdy && (|req)) w_state_next = S_SETUP;
            S_SETUP:   if (r_cnt == c_SETUP_LAST) w_state_next = S_START;
            S_START:   w_state_next = S_WAIT_LO;
            S_WAIT_LO: if (!spi_rdy) w_state_next = S_WAIT_HI;
            S_WAIT_HI: if (spi_rdy) w_state_next = S_DONE;
            S_DONE:    w_state_next = lock[r_owner] ? S_HOLD : S_RELEASE;
            S_HOLD: begin
                if (req[r_owner]) begin
                    w_state_next = S_START;
                end else if (!lock[r_owner] || w_to_expire) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: if (r_cnt == c_HOLD_LAST) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Shared CS setup / CS hold cycle counter, cleared on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == S_SETUP) || (r_state == S_RELEASE)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered outputs, updated on the transitions that own them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= '0;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_ss_n       <= '1;
            r_done       <= '0;
            r_spi_start  <= 1'b0;
            r_spi_fast   <= 1'b0;
            r_spi_dataTx <= '0;
            r_rx_data    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_spi_start <= (w_state_next == S_START);
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= '0;

            if ((r_state == S_IDLE) && (w_state_next == S_SETUP)) begin
                r_owner <= w_winner;
                r_gnt   <= w_win_oh;
                r_ss_n  <= ~w_win_oh;
            end

            // Engine controls are captured once per word and then held
            if (w_state_next == S_START) begin
                r_spi_fast   <= fast[r_owner];
                r_spi_dataTx <= tx_data[{r_owner, 5'd0} +: 32];
            end

            if (w_state_next == S_DONE) begin
                r_rx_data <= spi_dataRx;
                r_done    <= r_gnt;
            end

            if ((w_state_next == S_RELEASE) && (r_state != S_RELEASE)) begin
                r_gnt  <= '0;
                r_ss_n <= '1;
                r_ptr  <= (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
            end
        end
    end

    assign gnt        = r_gnt;
    assign ss_n       = r_ss_n;
    assign done       = r_done;
    assign rx_data    = r_rx_data;
    assign busy       = r_busy;
    assign spi_start  = r_spi_start;
    assign spi_fast   = r_spi_fast;
    assign spi_dataTx = r_spi_dataTx;

endmodule
`default_nettype wire
